icache_tag_array_nway: RTL
==========================

ICACHE_TAG_ARRAY_NWAY -- requirements
Module: icache_tag_array_nway

Interface
REQ-001 SHALL have parameter NB_WAYS, default 4, meaning number of ways per set, range 1..8.
REQ-002 SHALL have parameter SET_ADDR_WIDTH, default 5, meaning log2 of the number of sets.
REQ-003 SHALL have parameter TAG_WIDTH, default 10, meaning stored tag bits per way, excluding the valid bit.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req  input  1  access request.
REQ-007 SHALL have port write  input  1  1 = write access, 0 = lookup.
REQ-008 SHALL have port addr  input  SET_ADDR_WIDTH  set index.
REQ-009 SHALL have port way_be  input  NB_WAYS  one-hot or multi-hot way select for writes.
REQ-010 SHALL have port wvalid  input  1  valid bit written with wdata.
REQ-011 SHALL have port wdata  input  TAG_WIDTH  tag to write; also the compare tag on lookups.
REQ-012 SHALL have port gnt  output  1  request accepted this cycle.
REQ-013 SHALL have port rvalid  output  1  lookup result valid; asserted one cycle after a granted lookup.
REQ-014 SHALL have port rdata  output  NB_WAYS*TAG_WIDTH  stored tags of the looked-up set; way w at bits [w*TAG_WIDTH +: TAG_WIDTH].
REQ-015 SHALL have port rvalid_way  output  NB_WAYS  stored valid bits of the looked-up set.
REQ-016 SHALL have port hit_way  output  NB_WAYS  per-way hit (valid and tag equal).
REQ-017 SHALL have port hit  output  1  OR of hit_way.
REQ-018 SHALL have port flush_req  input  1  single-cycle request to invalidate all entries.
REQ-019 SHALL have port busy  output  1  invalidation walk in progress.
REQ-020 SHALL have port flush_done  output  1  single-cycle pulse on the last cycle of a walk.

Function
REQ-021 SHALL store tags in non-reset storage (flop or latch array), 2^SET_ADDR_WIDTH x NB_WAYS x TAG_WIDTH, plus a separate valid-bit array of the same set and way dimensions.
REQ-022 SHALL implement FSM states INIT, IDLE and FLUSH; reset enters INIT.
REQ-023 SHALL, in INIT and FLUSH, use a set counter that starts at 0, clears the valid bits of all ways of one set per cycle, and increments by 1.
REQ-024 SHALL, when the counter equals 2^SET_ADDR_WIDTH-1, clear that set, pulse flush_done, and go to IDLE on the next edge; a walk takes exactly 2^SET_ADDR_WIDTH cycles.
REQ-025 SHALL hold busy=1 and gnt=0 for the whole of INIT and FLUSH; requests are not accepted and are not queued.
REQ-026 SHALL assert gnt = req & ~flush_req in IDLE, combinationally.
REQ-027 SHALL, on flush_req in IDLE, enter FLUSH; flush_req wins over a simultaneous req, and that req is not granted.
REQ-028 SHALL ignore flush_req in INIT or FLUSH; the walk is neither restarted nor extended.
REQ-029 SHALL, for a granted write, update the tag and valid bit of every way with way_be[w]=1 at addr; ways with way_be[w]=0 are unchanged; rvalid is not asserted.
REQ-030 SHALL, for a granted lookup, register the read of addr and the compare tag, and in the next cycle drive rvalid=1 with rdata, rvalid_way, hit_way and hit.
REQ-031 SHALL compute hit_way[w] = rvalid_way[w] & (rdata way w == registered compare tag).
REQ-032 SHALL return the newly written data to a lookup granted in the cycle after a write to the same set (write-then-read coherent).
REQ-033 SHALL hold rdata, rvalid_way, hit_way and hit at their last values when rvalid=0; only rvalid is qualifying.
REQ-034 SHALL support back-to-back granted lookups at one per cycle, with rvalid staying high.

Reset
REQ-035 SHALL, while rst_n=0 at a rising edge, set state=INIT, counter=0, rvalid=0, flush_done=0, hit_way=0, hit=0, rvalid_way=0, and rdata=0.
REQ-036 SHALL drive busy=1 and gnt=0 during and immediately after reset until INIT completes.
REQ-037 SHALL, when reset is asserted mid-walk or mid-lookup, abandon the operation; the walk restarts from set 0 and no rvalid is produced for the abandoned lookup.

Verification
REQ-038 SHALL verify reset release with defaults -> busy=1 for exactly 32 cycles, flush_done pulses on cycle 32, and gnt=0 throughout.
REQ-039 SHALL verify write addr=3, way_be=0100, wdata=0x2A5, wvalid=1, then lookup addr=3 with wdata=0x2A5 the next cycle -> rvalid=1, hit_way=0100, hit=1.
REQ-040 SHALL verify a lookup of addr=3 with wdata=0x2A4 -> rvalid=1, hit=0, and rdata way2=0x2A5.
REQ-041 SHALL verify flush_req and req asserted in the same IDLE cycle -> gnt=0, a 32-cycle walk, then a lookup of addr=3 with 0x2A5 -> hit=0 and rvalid_way=0000.
REQ-042 SHALL verify flush_req during the walk at cycle 10 -> flush_done still occurs at cycle 32 and not later.
REQ-043 SHALL verify reset at cycle 15 of a walk -> after release the walk takes a full 32 cycles again and rvalid=0 throughout.

Source files
------------

// File: rtl/icache_tag_array_nway.sv
// Instruction-cache tag array: NB_WAYS tags plus valid bits per set, with
// single-cycle writes, registered lookups that report a per-way hit, and an
// invalidation walk that clears one set per cycle after reset or on flush_req.
module icache_tag_array_nway #(
   parameter int NB_WAYS        = 4,
   parameter int SET_ADDR_WIDTH = 5,
   parameter int TAG_WIDTH      = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req,
   input  logic                         write,
   input  logic [SET_ADDR_WIDTH-1:0]    addr,
   input  logic [NB_WAYS-1:0]           way_be,
   input  logic                         wvalid,
   input  logic [TAG_WIDTH-1:0]         wdata,
   output logic                         gnt,
   output logic                         rvalid,
   output logic [NB_WAYS*TAG_WIDTH-1:0] rdata,
   output logic [NB_WAYS-1:0]           rvalid_way,
   output logic [NB_WAYS-1:0]           hit_way,
   output logic                         hit,
   input  logic                         flush_req,
   output logic                         busy,
   output logic                         flush_done
);

   localparam int                        NUM_SETS = 1 << SET_ADDR_WIDTH;
   localparam logic [SET_ADDR_WIDTH-1:0] LAST_SET = SET_ADDR_WIDTH'(NUM_SETS - 1);

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      FLUSH
   } state_t;

   state_t                       state;
   logic [SET_ADDR_WIDTH-1:0]    walk_set;
   logic [TAG_WIDTH-1:0]         tag_mem   [NUM_SETS][NB_WAYS];
   logic [NB_WAYS-1:0]           valid_mem [NUM_SETS];
   logic [TAG_WIDTH-1:0]         cmp_tag;
   logic                         walking;
   logic                         wr_en;
   logic                         rd_en;

   // Both INIT and FLUSH run the same walk; only IDLE accepts accesses.
   assign walking = (state != IDLE);

   // Grant is gated by rst_n so nothing can be accepted while reset is held,
   // even if the state register still says IDLE from before reset.
   assign gnt   = rst_n && (state == IDLE) && req && !flush_req;
   assign wr_en = gnt && write;
   assign rd_en = gnt && !write;

   assign busy       = !rst_n || walking;
   assign flush_done = rst_n && walking && (walk_set == LAST_SET);

   // Walk controller: INIT after reset, FLUSH on request, one set per cycle.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= INIT;
         walk_set <= '0;
      end else begin
         case (state)
            INIT, FLUSH: begin
               if (walk_set == LAST_SET) begin
                  state    <= IDLE;
                  walk_set <= '0;
               end else begin
                  walk_set <= walk_set + 1'b1;
               end
            end
            IDLE: begin
               if (flush_req) begin
                  state <= FLUSH;
               end
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

   // Tag storage: written per way on granted writes.
   // NOTE: the tag array has no reset; a tag means nothing until its valid
   // bit is set, and the walk after every reset clears all valid bits.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int w = 0; w < NB_WAYS; w++) begin
            if (way_be[w]) begin
               tag_mem[addr][w] <= wdata;
            end
         end
      end
   end

   // Valid bits: cleared a set at a time by the walk, else set by writes.
   always_ff @(posedge clk) begin
      if (walking) begin
         valid_mem[walk_set] <= '0;
      end else if (wr_en) begin
         for (int w = 0; w < NB_WAYS; w++) begin
            if (way_be[w]) begin
               valid_mem[addr][w] <= wvalid;
            end
         end
      end
   end

   // Lookup read port: capture the set and compare tag; results hold until
   // the next granted lookup so rvalid alone qualifies them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid     <= 1'b0;
         rdata      <= '0;
         rvalid_way <= '0;
         cmp_tag    <= '0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) begin
            for (int w = 0; w < NB_WAYS; w++) begin
               rdata[w*TAG_WIDTH +: TAG_WIDTH] <= tag_mem[addr][w];
            end
            rvalid_way <= valid_mem[addr];
            cmp_tag    <= wdata;
         end
      end
   end

   // Per-way tag compare on the captured set.
   // NOTE: combinational outputs get a default first so no path infers a latch.
   always_comb begin
      hit_way = '0;
      for (int w = 0; w < NB_WAYS; w++) begin
         hit_way[w] = rvalid_way[w] && (rdata[w*TAG_WIDTH +: TAG_WIDTH] == cmp_tag);
      end
   end

   assign hit = |hit_way;

endmodule
